// File: rtl/less_bist_pkg.sv
// Shared types and constants for the set-less-than BIST sequencer:
// FSM states, the directed vector table and the LFSR seed/taps.
package less_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK,
        DONE
    } bist_state_t;

    localparam int NUM_DIRECTED = 5;

    // Stored as 8-bit two's complement; a narrower WIDTH keeps the low bits.
    localparam logic [NUM_DIRECTED-1:0][7:0] DIR_A = {8'h11, 8'h03, 8'h15, 8'h0B, 8'hF4};
    localparam logic [NUM_DIRECTED-1:0][7:0] DIR_B = {8'h03, 8'h11, 8'h15, 8'hF4, 8'h0B};
    // Bit k is the expected result of vector k at WIDTH=6.
    localparam logic [NUM_DIRECTED-1:0]      DIR_EXP = 5'b01001;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/less_bist_if.sv
// Handshake and result bundle between the BIST sequencer and the comparator side.
interface less_bist_if #(
    parameter int WIDTH = 6
);
    logic             start;
    logic [WIDTH-1:0] cmp_result;
    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_b;
    logic             busy;
    logic             done;
    logic             pass;
    logic [7:0]       fail_count;
    logic [WIDTH-1:0] first_fail_a;
    logic [WIDTH-1:0] first_fail_b;

    modport master (
        output start, cmp_result,
        input  cmp_a, cmp_b, busy, done, pass, fail_count, first_fail_a, first_fail_b
    );

    modport slave (
        input  start, cmp_result,
        output cmp_a, cmp_b, busy, done, pass, fail_count, first_fail_a, first_fail_b
    );

endinterface

// File: rtl/less_bist_lfsr16.sv
// 16-bit right-shifting Galois LFSR for the random vector phase.
module lfsr16
    import less_bist_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load,
    input  logic        advance,
    output logic [15:0] value
);

    always_ff @(posedge clock) begin
        if (!reset_n || load) begin
            value <= LFSR_SEED;
        end else if (advance) begin
            value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/less_bist.sv
// BIST sequencer for the set-less-than comparator: drives directed then LFSR
// vectors, checks each signed result and accumulates a mismatch summary.
module less_bist
    import less_bist_pkg::*;
#(
    parameter int WIDTH      = 6,
    parameter int NUM_RANDOM = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    less_bist_if.slave bus
);

    localparam int         NVEC = NUM_DIRECTED + NUM_RANDOM;
    localparam logic [8:0] LAST = 9'(NVEC - 1);

    bist_state_t      state;
    logic [8:0]       idx;
    logic [8:0]       next_idx;
    logic [WIDTH-1:0] next_a;
    logic [WIDTH-1:0] next_b;
    logic [15:0]      lfsr_val;
    logic             lfsr_load;
    logic             lfsr_adv;
    logic             exp_less;
    logic             mismatch;
    logic             unused_lfsr;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Reseed on every accepted start; step once a random vector has been driven.
    assign lfsr_load = (state == IDLE) && bus.start;
    assign lfsr_adv  = (state == DRIVE) && (idx >= 9'(NUM_DIRECTED));

    lfsr16 u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .value   (lfsr_val)
    );

    // Upper LFSR bits go unused when WIDTH < 8.
    assign unused_lfsr = ^lfsr_val;

    // Vector to present at the next DRIVE: index 0 from IDLE, k+1 from CHECK.
    always_comb begin
        next_idx = (state == CHECK) ? idx + 9'd1 : 9'd0;
        if (next_idx < 9'(NUM_DIRECTED)) begin
            next_a = DIR_A[next_idx[2:0]][WIDTH-1:0];
            next_b = DIR_B[next_idx[2:0]][WIDTH-1:0];
        end else begin
            next_a = lfsr_val[WIDTH-1:0];
            next_b = lfsr_val[2*WIDTH-1:WIDTH];
        end
    end

    assign exp_less = $signed(bus.cmp_a) < $signed(bus.cmp_b);
    assign mismatch = bus.cmp_result != {{(WIDTH-1){1'b0}}, exp_less};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state            <= IDLE;
            idx              <= '0;
            bus.cmp_a        <= '0;
            bus.cmp_b        <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.pass         <= 1'b0;
            bus.fail_count   <= '0;
            bus.first_fail_a <= '0;
            bus.first_fail_b <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state            <= DRIVE;
                        idx              <= '0;
                        bus.cmp_a        <= next_a;
                        bus.cmp_b        <= next_b;
                        bus.busy         <= 1'b1;
                        bus.pass         <= 1'b0;
                        bus.fail_count   <= '0;
                        bus.first_fail_a <= '0;
                        bus.first_fail_b <= '0;
                    end
                end
                DRIVE: state <= CHECK;
                CHECK: begin
                    if (mismatch) begin
                        bus.fail_count <= sat_inc(bus.fail_count);
                        if (bus.fail_count == 8'd0) begin
                            bus.first_fail_a <= bus.cmp_a;
                            bus.first_fail_b <= bus.cmp_b;
                        end
                    end
                    if (idx == LAST) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.pass <= (bus.fail_count == 8'd0) && !mismatch;
                    end else begin
                        state     <= DRIVE;
                        idx       <= next_idx;
                        bus.cmp_a <= next_a;
                        bus.cmp_b <= next_b;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_less_bist.sv
// Self-checking bench for less_bist: fault-injecting comparator models and a
// vector/result reference model built from the directed table and LFSR rule.
module tb_less_bist;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    less_bist_if #(.WIDTH(6)) bus ();
    less_bist_if #(.WIDTH(6)) bus2 ();

    less_bist #(.WIDTH(6), .NUM_RANDOM(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    less_bist #(.WIDTH(6), .NUM_RANDOM(255)) dut2 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         mode = 0;
    logic [5:0] mask_tab[64];

    logic [5:0] mva[$];
    logic [5:0] mvb[$];
    int         exp_fails;
    logic [7:0] exp_fc;
    logic [5:0] exp_ff_a;
    logic [5:0] exp_ff_b;

    // Comparator under test: 0 good, 1 stuck-0, 2 returns 2 on A==B,
    // 3 unsigned, 4 random corruption keyed on A^B.
    function automatic logic [5:0] comp(input int m, input logic [5:0] a, input logic [5:0] b);
        logic lt;
        lt = $signed(a) < $signed(b);
        case (m)
            0: return {5'b0, lt};
            1: return 6'd0;
            2: return (a == b) ? 6'd2 : {5'b0, lt};
            3: return {5'b0, a < b};
            4: return {5'b0, lt} ^ mask_tab[a ^ b];
            default: return 6'h3F;
        endcase
    endfunction

    assign bus.cmp_result  = comp(mode, bus.cmp_a, bus.cmp_b);
    assign bus2.cmp_result = 6'h3F;

    task automatic model_run(input int nrand, input int m);
        int          dir_a[5] = '{-12, 11, 21, 3, 17};
        int          dir_b[5] = '{11, -12, 21, 17, 3};
        logic [15:0] s;
        logic [5:0]  e;
        mva.delete();
        mvb.delete();
        for (int i = 0; i < 5; i++) begin
            mva.push_back(6'(dir_a[i]));
            mvb.push_back(6'(dir_b[i]));
        end
        s = 16'hACE1;
        for (int i = 0; i < nrand; i++) begin
            mva.push_back(s[5:0]);
            mvb.push_back(s[11:6]);
            s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
        end
        exp_fails = 0;
        exp_ff_a  = 6'd0;
        exp_ff_b  = 6'd0;
        for (int i = 0; i < mva.size(); i++) begin
            e = ($signed(mva[i]) < $signed(mvb[i])) ? 6'd1 : 6'd0;
            if (comp(m, mva[i], mvb[i]) != e) begin
                if (exp_fails == 0) begin
                    exp_ff_a = mva[i];
                    exp_ff_b = mvb[i];
                end
                exp_fails++;
            end
        end
        exp_fc = (exp_fails > 255) ? 8'hFF : 8'(exp_fails);
    endtask

    task automatic run_main(input string tag, input bit hold_start);
        int nv;
        bit eb;
        bit ed;
        nv = mva.size();
        @(negedge clock);
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        if (!hold_start) bus.start = 1'b0;
        for (int cyc = 1; cyc <= 2 * nv + 3; cyc++) begin
            if (cyc == 2 * nv + 1) bus.start = 1'b0;
            eb = (cyc <= 2 * nv);
            ed = (cyc == 2 * nv + 1);
            n_vec++;
            if (bus.busy !== eb || bus.done !== ed) begin
                n_err++;
                $display("FAIL %s busy/done cycle %0d: got %b/%b want %b/%b", tag, cyc, bus.busy, bus.done, eb, ed);
            end
            if (cyc % 2 == 1 && cyc < 2 * nv) begin
                n_vec++;
                if (bus.cmp_a !== mva[(cyc-1)/2] || bus.cmp_b !== mvb[(cyc-1)/2]) begin
                    n_err++;
                    $display("FAIL %s vector %0d: got %h/%h want %h/%h", tag, (cyc-1)/2, bus.cmp_a, bus.cmp_b, mva[(cyc-1)/2], mvb[(cyc-1)/2]);
                end
            end
            @(posedge clock);
            #1;
        end
        n_vec++;
        if (bus.pass !== (exp_fails == 0)) begin
            n_err++;
            $display("FAIL %s pass: got %b want %b", tag, bus.pass, exp_fails == 0);
        end
        n_vec++;
        if (bus.fail_count !== exp_fc) begin
            n_err++;
            $display("FAIL %s fail_count: got %0d want %0d", tag, bus.fail_count, exp_fc);
        end
        n_vec++;
        if (bus.first_fail_a !== exp_ff_a || bus.first_fail_b !== exp_ff_b) begin
            n_err++;
            $display("FAIL %s first_fail: got %h/%h want %h/%h", tag, bus.first_fail_a, bus.first_fail_b, exp_ff_a, exp_ff_b);
        end
        n_vec++;
        if (bus.cmp_a !== mva[nv-1] || bus.cmp_b !== mvb[nv-1]) begin
            n_err++;
            $display("FAIL %s hold last vector: got %h/%h want %h/%h", tag, bus.cmp_a, bus.cmp_b, mva[nv-1], mvb[nv-1]);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus2.start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_vec++;
        if ({bus.cmp_a, bus.cmp_b, bus.busy, bus.done, bus.pass, bus.fail_count, bus.first_fail_a, bus.first_fail_b} !== '0) begin
            n_err++;
            $display("FAIL reset outputs: got a=%h b=%h busy=%b done=%b pass=%b fc=%0d ff=%h/%h want all 0",
                     bus.cmp_a, bus.cmp_b, bus.busy, bus.done, bus.pass, bus.fail_count, bus.first_fail_a, bus.first_fail_b);
        end
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle busy: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_mode(input string tag, input int m);
        mode = m;
        model_run(16, m);
        run_main(tag, 1'b0);
    endtask

    task automatic test_random_faults();
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < 64; i++)
                mask_tab[i] = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            repeat ($urandom_range(0, 5)) @(posedge clock);
            test_mode("random_faults", 4);
        end
    endtask

    task automatic test_midrun_reset();
        mode = 3;
        @(negedge clock);
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (19) @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        n_vec++;
        if ({bus.cmp_a, bus.cmp_b, bus.busy, bus.done, bus.pass, bus.fail_count, bus.first_fail_a, bus.first_fail_b} !== '0) begin
            n_err++;
            $display("FAIL midrun reset outputs: got a=%h b=%h busy=%b done=%b pass=%b fc=%0d ff=%h/%h want all 0",
                     bus.cmp_a, bus.cmp_b, bus.busy, bus.done, bus.pass, bus.fail_count, bus.first_fail_a, bus.first_fail_b);
        end
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        test_mode("after_reset", 0);
    endtask

    task automatic test_back_to_back();
        mode = 0;
        model_run(16, 0);
        run_main("held_start", 1'b1);
        run_main("restart", 1'b0);
    endtask

    task automatic test_saturation();
        int done_cyc;
        done_cyc = -1;
        @(negedge clock);
        bus2.start = 1'b1;
        @(posedge clock);
        #1;
        bus2.start = 1'b0;
        for (int cyc = 1; cyc <= 600 && done_cyc < 0; cyc++) begin
            if (bus2.done === 1'b1) done_cyc = cyc;
            else begin
                @(posedge clock);
                #1;
            end
        end
        n_vec++;
        if (done_cyc != 521) begin
            n_err++;
            $display("FAIL saturation done cycle: got %0d want 521", done_cyc);
        end
        n_vec++;
        if (bus2.fail_count !== 8'hFF || bus2.pass !== 1'b0) begin
            n_err++;
            $display("FAIL saturation count/pass: got %0d/%b want 255/0", bus2.fail_count, bus2.pass);
        end
        n_vec++;
        if (bus2.first_fail_a !== 6'h34 || bus2.first_fail_b !== 6'h0B) begin
            n_err++;
            $display("FAIL saturation first_fail: got %h/%h want 34/0b", bus2.first_fail_a, bus2.first_fail_b);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mask_tab[i] = 6'd0;
        bus.start  = 1'b0;
        bus2.start = 1'b0;
        test_reset();
        test_mode("correct", 0);
        test_mode("stuck_zero", 1);
        test_mode("eq_fault", 2);
        test_mode("unsigned", 3);
        test_random_faults();
        test_midrun_reset();
        test_back_to_back();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
